// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives a registered-read instruction memory and buffers
// returned words in a 2-entry FIFO. Redirects flush the pipe, and a misaligned target faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_inflight_pc;
  logic        r_inflight;
  logic        r_fault;
  logic [31:0] r_fault_pc;
  logic [1:0]  r_count;
  logic [31:0] r_pc0;
  logic [31:0] r_pc1;
  logic [31:0] r_data0;
  logic [31:0] r_data1;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_misaligned;
  logic [2:0]  w_occ;

  // An issue is allowed only if the word it will return is guaranteed a FIFO slot.
  always_comb begin
    w_pop        = (r_count != 2'd0) && inst_ready;
    w_push       = r_inflight && !redirect_valid;
    w_occ        = {1'b0, r_count} + {2'b00, r_inflight};
    w_issue      = (r_state == ST_RUN) && !redirect_valid &&
                   (w_occ < (3'd2 + {2'b00, w_pop}));
    w_misaligned = (redirect_pc[1:0] != 2'b00);
  end

  // Run/fault FSM with fetch pointer, inflight tracking and fault capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'd0;
      r_fault       <= 1'b0;
      r_fault_pc    <= 32'd0;
    end else if (redirect_valid) begin
      r_inflight <= 1'b0;
      if (w_misaligned) begin
        r_state    <= ST_FAULT;
        r_fault    <= 1'b1;
        r_fault_pc <= redirect_pc;
      end else begin
        r_state    <= ST_RUN;
        r_fault    <= 1'b0;
        r_fetch_pc <= redirect_pc;
      end
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end
    end
  end

  // Shift-style FIFO: entry 0 is always the head, so the outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_pc0   <= 32'd0;
      r_pc1   <= 32'd0;
      r_data0 <= 32'd0;
      r_data1 <= 32'd0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc0   <= r_inflight_pc;
            r_data0 <= imem_data;
          end else begin
            r_pc1   <= r_inflight_pc;
            r_data1 <= imem_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_pc0   <= r_pc1;
          r_data0 <= r_data1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_pc0   <= r_inflight_pc;
            r_data0 <= imem_data;
          end else begin
            r_pc0   <= r_pc1;
            r_data0 <= r_data1;
            r_pc1   <= r_inflight_pc;
            r_data1 <= imem_data;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign imem_addr   = r_fetch_pc;
  assign inst_valid  = (r_count != 2'd0);
  assign inst_data   = r_data0;
  assign inst_pc     = r_pc0;
  assign fetch_fault = r_fault;
  assign fault_pc    = r_fault_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model compared every cycle,
// plus directed literal checks for reset, streaming, stall, redirect, fault and wrap cases.
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  fetch_unit #(.RESET_PC(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  // The memory content is the word index relative to BASE.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a - BASE) >> 2;
  endfunction

  always @(posedge clk) imem_data <= rom_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: queue of buffered pcs, queue of requested pcs still in memory.
  logic [31:0] m_q[$];
  logic [31:0] m_pipe[$];
  logic [31:0] m_pc;
  logic [31:0] m_fault_pc;
  bit          m_fault;
  bit          m_run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pipe.delete();
      m_pc       = BASE;
      m_fault    = 1'b0;
      m_fault_pc = 32'd0;
      m_run      = 1'b1;
    end else begin
      bit pop;
      int occ;
      pop = (m_q.size() != 0) && inst_ready;
      if (redirect_valid) begin
        m_q.delete();
        m_pipe.delete();
        if (redirect_pc[1:0] == 2'b00) begin
          m_pc    = redirect_pc;
          m_run   = 1'b1;
          m_fault = 1'b0;
        end else begin
          m_run      = 1'b0;
          m_fault    = 1'b1;
          m_fault_pc = redirect_pc;
        end
      end else begin
        occ = m_q.size() + m_pipe.size() - (pop ? 1 : 0);
        if (pop) void'(m_q.pop_front());
        if (m_pipe.size() != 0) m_q.push_back(m_pipe.pop_front());
        if (m_run && occ < 2) begin
          m_pipe.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, (m_q.size() != 0)});
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      chk("fault_pc", fault_pc, m_fault_pc);
      if (m_q.size() != 0) begin
        chk("inst_pc", inst_pc, m_q[0]);
        chk("inst_data", inst_data, rom_word(m_q[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
  endtask

  task automatic reset_literals();
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
  endtask

  task automatic first_two_literals();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("c2_valid", {31'd0, inst_valid}, 32'd1);
    chk("c2_pc", inst_pc, 32'h0100_0000);
    chk("c2_data", inst_data, 32'd0);
    @(negedge clk);
    chk("c3_pc", inst_pc, 32'h0100_0004);
    chk("c3_data", inst_data, 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    chk_on         = 1'b1;
    repeat (3) step();
    #1;
    reset_literals();

    // Reset release, full-rate streaming
    step();
    rst_n = 1'b1;
    first_two_literals();
    repeat (4) step();

    // Consumer stall for five cycles
    inst_ready = 1'b0;
    repeat (5) step();
    inst_ready = 1'b1;
    @(negedge clk);
    chk("post_stall_valid", {31'd0, inst_valid}, 32'd1);
    repeat (4) step();

    // Redirect with the FIFO full
    inst_ready = 1'b0;
    repeat (4) step();
    inst_ready = 1'b1;
    redirect(32'h0100_0040);
    @(negedge clk);
    chk("r1_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("r2_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("r3_valid", {31'd0, inst_valid}, 32'd1);
    chk("r3_pc", inst_pc, 32'h0100_0040);
    chk("r3_data", inst_data, 32'd16);
    repeat (2) step();

    // Redirect during an accepted handshake at full rate
    redirect(32'h0100_0100);
    repeat (6) step();

    // Misaligned redirect faults, then an aligned redirect recovers
    redirect(32'h0100_0042);
    repeat (6) step();
    chk("flt_fault", {31'd0, fetch_fault}, 32'd1);
    chk("flt_fault_pc", fault_pc, 32'h0100_0042);
    chk("flt_valid", {31'd0, inst_valid}, 32'd0);
    redirect(32'h0100_0080);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rec_pc", inst_pc, 32'h0100_0080);
    chk("rec_data", inst_data, 32'd32);
    chk("rec_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rec_fault_pc", fault_pc, 32'h0100_0042);

    // Address wrap with an irregular consumer
    step();
    redirect(32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) begin
      inst_ready = (i % 3) != 0;
      step();
    end
    inst_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset mid-stream
    #1;
    rst_n = 1'b0;
    #1;
    reset_literals();
    step();
    step();
    rst_n = 1'b1;
    first_two_literals();
    repeat (5) step();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
